serial_alu_seq: RTL and testbench

SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

---
 rtl/serial_alu_seq.sv | 104 ++++++++++
 tb/tb_serial_alu_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial ALU sequencer driving an external 1-bit ALU slice, LSB first
module serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_cin,
    output logic             alu_bin,
    output logic [2:0]       alu_sel,
    input  logic             alu_y,
    input  logic             alu_cout,
    input  logic             alu_bout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] work;
    logic [2:0]       op_reg;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic             run;
    logic             last;
    logic             cy_next;
    logic [WIDTH-1:0] res_next;

    // Slice drive: operand bits and carry/borrow only while running, opcode always visible
    always_comb begin
        run      = state == RUN;
        last     = cnt == CW'(WIDTH - 1);
        alu_a    = run ? a_reg[cnt] : 1'b0;
        alu_b    = run ? b_reg[cnt] : 1'b0;
        alu_sel  = op_reg;
        alu_cin  = (run && (op_reg == OP_ADD || op_reg == OP_SUB)) ? cy : 1'b0;
        alu_bin  = (run && op_reg == OP_SUB) ? cy : 1'b0;
        cy_next  = (op_reg == OP_ADD) ? alu_cout : (op_reg == OP_SUB) ? alu_bout : 1'b0;
        res_next = {alu_y, work[WIDTH-1:1]};
    end

    // Sequencer: capture on accept, shift one slice result per RUN cycle, publish on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            work       <= '0;
            op_reg     <= OP_ADD;
            cy         <= 1'b0;
            cnt        <= '0;
            result     <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state  <= RUN;
                    busy   <= 1'b1;
                    a_reg  <= a;
                    b_reg  <= b;
                    op_reg <= op;
                    cy     <= (op == OP_ADD || op == OP_SUB) ? cin : 1'b0;
                    cnt    <= '0;
                end
                RUN: begin
                    work <= res_next;
                    cy   <= cy_next;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        result     <= res_next;
                        carry_flag <= cy_next;
                        zero_flag  <= res_next == '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq: randomized and directed checks of serial_alu_seq against an arithmetic reference model
module tb_serial_alu_seq;
    localparam int W = 8;

    logic         clk = 0;
    logic         rst_n = 0;
    logic         start = 0;
    logic [2:0]   op = 0;
    logic [W-1:0] a = 0, b = 0;
    logic         cin = 0;
    logic         busy, done, carry_flag, zero_flag;
    logic [W-1:0] result;
    logic         alu_a, alu_b, alu_cin, alu_bin;
    logic [2:0]   alu_sel;
    logic         alu_y, alu_cout, alu_bout;

    int checks = 0;
    int fails = 0;
    logic [W-1:0] last_res = 0;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .result(result), .carry_flag(carry_flag), .zero_flag(zero_flag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_bin(alu_bin), .alu_sel(alu_sel),
        .alu_y(alu_y), .alu_cout(alu_cout), .alu_bout(alu_bout)
    );

    always #5 clk = ~clk;

    // External 1-bit ALU slice
    always_comb begin
        alu_y = (alu_sel == 3'd0 || alu_sel == 3'd1) ? (alu_a ^ alu_b ^ alu_cin) :
                (alu_sel == 3'd2) ? (alu_a & alu_b) :
                (alu_sel == 3'd3) ? ~(alu_a | alu_b) :
                (alu_sel == 3'd7) ? (alu_a ^ alu_b) : 1'b0;
        alu_cout = (alu_sel == 3'd0) ? ((alu_a & alu_b) | (alu_cin & (alu_a ^ alu_b))) : 1'b0;
        alu_bout = (alu_sel == 3'd1) ? ((~alu_a & alu_b) | (alu_bin & ~(alu_a ^ alu_b))) : 1'b0;
    end

    // Reference: {carry/borrow, result} from whole-word arithmetic
    function automatic logic [W:0] model(input logic [2:0] o, input logic [W-1:0] x, y, input logic c);
        logic [W:0] d;
        case (o)
            3'd0: model = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
            3'd1: begin
                d = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
                model = d;
            end
            3'd2: model = {1'b0, x & y};
            3'd3: model = {1'b0, ~(x | y)};
            3'd7: model = {1'b0, x ^ y};
            default: model = '0;
        endcase
    endfunction

    // One full operation; optionally pulses start with other operands 3 cycles into RUN
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, y, input logic c,
                         input string tag, input bit inject);
        logic [W:0] exp;
        exp = model(o, x, y, c);
        @(negedge clk);
        start = 1; op = o; a = x; b = y; cin = c;
        @(posedge clk); #1;
        start = 0; op = 3'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        checks++;
        if (busy !== 1 || alu_sel !== o) begin
            fails++;
            $display("FAIL %s accept: busy=%b sel=%0d, want busy=1 sel=%0d", tag, busy, alu_sel, o);
        end
        for (int n = 1; n < W; n++) begin
            if (inject && n == 3) begin
                start = 1; op = 3'd2; a = ~x; b = ~y;
            end
            if (inject && n == 4) start = 0;
            @(posedge clk); #1;
            checks++;
            if (done !== 0 || busy !== 1 || result !== last_res) begin
                fails++;
                $display("FAIL %s run edge %0d: done=%b busy=%b result=%h, want 0 1 %h", tag, n, done, busy, result, last_res);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1 || busy !== 1 || result !== exp[W-1:0] || carry_flag !== exp[W] ||
            zero_flag !== (exp[W-1:0] == 0)) begin
            fails++;
            $display("FAIL %s done: done=%b busy=%b result=%h c=%b z=%b, want 1 1 %h %b %b",
                     tag, done, busy, result, carry_flag, zero_flag, exp[W-1:0], exp[W], exp[W-1:0] == 0);
        end
        last_res = exp[W-1:0];
        @(posedge clk); #1;
        checks++;
        if (done !== 0 || busy !== 0 || result !== last_res || alu_a !== 0 || alu_b !== 0 ||
            alu_cin !== 0 || alu_bin !== 0 || alu_sel !== o) begin
            fails++;
            $display("FAIL %s idle: done=%b busy=%b result=%h alu=%b%b%b%b sel=%0d", tag, done, busy,
                     result, alu_a, alu_b, alu_cin, alu_bin, alu_sel);
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        #12;
        checks++;
        if (busy !== 0 || done !== 0 || result !== 0 || carry_flag !== 0 || zero_flag !== 1 ||
            alu_a !== 0 || alu_b !== 0 || alu_cin !== 0 || alu_bin !== 0 || alu_sel !== 0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b result=%h c=%b z=%b sel=%0d", busy, done, result,
                     carry_flag, zero_flag, alu_sel);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_directed;
        do_op(3'd0, 8'hFF, 8'h01, 0, "add_wrap", 0);
        do_op(3'd1, 8'h05, 8'h07, 0, "sub_borrow", 0);
        do_op(3'd1, 8'h07, 8'h05, 0, "sub_plain", 0);
        do_op(3'd2, 8'hF0, 8'h3C, 1, "and", 0);
        do_op(3'd3, 8'hF0, 8'h3C, 1, "nor", 0);
        do_op(3'd7, 8'hF0, 8'h3C, 1, "xor", 0);
        do_op(3'd4, 8'hAA, 8'h55, 1, "illegal", 0);
        do_op(3'd0, 8'h80, 8'h7F, 1, "add_cin", 0);
        do_op(3'd1, 8'h00, 8'h00, 1, "sub_bin", 0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++)
            do_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom), "random", 0);
    endtask

    task automatic test_start_ignored;
        do_op(3'd0, 8'h21, 8'h43, 0, "ignored_start", 1);
        @(posedge clk); #1;
        checks++;
        if (busy !== 0 || done !== 0) begin
            fails++;
            $display("FAIL ignored_start queued: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_midrun;
        @(negedge clk);
        start = 1; op = 3'd0; a = 8'h99; b = 8'h11; cin = 0;
        @(posedge clk); #1;
        start = 0;
        repeat (4) @(posedge clk);
        #1 rst_n = 0;
        #1;
        checks++;
        if (busy !== 0 || done !== 0 || result !== 0 || zero_flag !== 1 || alu_a !== 0 || alu_b !== 0) begin
            fails++;
            $display("FAIL reset_midrun: busy=%b done=%b result=%h z=%b, want 0 0 00 1", busy, done, result, zero_flag);
        end
        last_res = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        for (int n = 0; n < W + 2; n++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 0 || busy !== 0) begin
                fails++;
                $display("FAIL reset_midrun leftover: done=%b busy=%b at %0d", done, busy, n);
            end
        end
        do_op(3'd0, 8'h12, 8'h34, 0, "after_reset", 0);
    endtask

    task automatic test_back_to_back;
        int n, first, second;
        logic [W:0] e1, e2;
        e1 = model(3'd7, 8'h5A, 8'h0F, 0);
        e2 = model(3'd0, 8'h33, 8'h44, 1);
        @(negedge clk);
        start = 1; op = 3'd7; a = 8'h5A; b = 8'h0F; cin = 0;
        @(posedge clk); #1;
        op = 3'd0; a = 8'h33; b = 8'h44; cin = 1;
        n = 0; first = 0; second = 0;
        while (second == 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done && first == 0) begin
                first = n;
                checks++;
                if (result !== e1[W-1:0]) begin
                    fails++;
                    $display("FAIL b2b first result=%h want %h", result, e1[W-1:0]);
                end
            end else if (done) begin
                second = n;
                start = 0;
                checks++;
                if (result !== e2[W-1:0] || carry_flag !== e2[W]) begin
                    fails++;
                    $display("FAIL b2b second result=%h c=%b want %h %b", result, carry_flag, e2[W-1:0], e2[W]);
                end
            end
        end
        start = 0;
        checks++;
        if (first !== W || second !== 2 * W + 2) begin
            fails++;
            $display("FAIL b2b timing: done at %0d and %0d, want %0d and %0d", first, second, W, 2 * W + 2);
        end
        repeat (W + 3) @(posedge clk);
        last_res = e2[W-1:0];
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_start_ignored;
        test_reset_midrun;
        test_back_to_back;
        do_op(3'd3, 8'h00, 8'h00, 0, "final_nor", 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
